// File: rtl/mem_slot_sequencer_pkg.sv
// rtl/mem_slot_sequencer_pkg.sv - bus-cycle, ram-size encodings and address mask widths
package mem_slot_sequencer_pkg;

  typedef enum logic [1:0] {
    BC_VIDEO = 2'd0,
    BC_CPU_A = 2'd1,
    BC_EXT   = 2'd2,
    BC_CPU_B = 2'd3
  } bus_cycle_e;

  typedef enum logic [1:0] {
    RAM_128K = 2'd0,
    RAM_512K = 2'd1,
    RAM_1M   = 2'd2,
    RAM_4M   = 2'd3
  } ram_size_e;

  localparam int MASK_W_128K = 17;
  localparam int MASK_W_512K = 19;
  localparam int MASK_W_1M   = 20;

  localparam logic [1:0] PH_ARB  = 2'd1;
  localparam logic [1:0] PH_LAST = 2'd3;

  // Number of low address bits that survive masking for a given RAM size.
  function automatic int keep_bits(input logic [1:0] cfg, input int addr_w);
    case (cfg)
      RAM_128K: return MASK_W_128K;
      RAM_512K: return MASK_W_512K;
      RAM_1M:   return MASK_W_1M;
      default:  return addr_w;
    endcase
  endfunction

endpackage

// File: rtl/mem_slot_sequencer_if.sv
// rtl/mem_slot_sequencer_if.sv - address/request bus between clients and the slot sequencer
interface mem_slot_sequencer_if #(
  parameter int NUM_EXT = 4,
  parameter int ADDR_W  = 22
);
  logic [ADDR_W-1:0]         cpu_addr;
  logic [ADDR_W-1:0]         video_addr;
  logic [NUM_EXT-1:0]        ext_req;
  logic [NUM_EXT*ADDR_W-1:0] ext_addr;
  logic [NUM_EXT-1:0]        ext_ack;
  logic [ADDR_W-1:0]         mem_addr;

  modport master (
    output cpu_addr, video_addr, ext_req, ext_addr,
    input  ext_ack, mem_addr
  );

  modport slave (
    input  cpu_addr, video_addr, ext_req, ext_addr,
    output ext_ack, mem_addr
  );
endinterface

// File: rtl/mem_slot_sequencer_rr_arbiter.sv
// rtl/mem_slot_sequencer_rr_arbiter.sv - round-robin priority search starting after the last grant
module rr_arbiter #(
  parameter int NUM_EXT = 4
) (
  input  logic [NUM_EXT-1:0]         req,
  input  logic [$clog2(NUM_EXT)-1:0] last,
  output logic [NUM_EXT-1:0]         grant_oh,
  output logic                       valid
);

  int idx;

  always_comb begin
    grant_oh = '0;
    valid    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_EXT; k++) begin
      idx = (int'(last) + k) % NUM_EXT;
      if (!valid && req[idx]) begin
        grant_oh[idx] = 1'b1;
        valid         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_slot_sequencer.sv
// rtl/mem_slot_sequencer.sv - 16-clock memory slot sequencer: video, cpu, arbitrated ext, cpu
module mem_slot_sequencer
  import mem_slot_sequencer_pkg::*;
#(
  parameter int NUM_EXT     = 4,
  parameter int ADDR_W      = 22,
  parameter int ROUND_ROBIN = 1,
  parameter int BASE_SHIFT  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 clk8_en_p,
  output logic                 clk8_en_n,
  output logic                 mem_latch,
  output logic [1:0]           bus_cycle,
  output logic                 video_sel,
  output logic                 cpu_sel,
  output logic                 ext_sel,
  input  logic [1:0]           ram_size_cfg,
  mem_slot_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_EXT);

  logic [1:0]         phase;
  bus_cycle_e         bc_q;
  bus_cycle_e         bc_d;
  logic [IDX_W-1:0]   slot_count;
  logic [IDX_W-1:0]   last_grant;
  logic [NUM_EXT-1:0] grant_oh;
  logic [NUM_EXT-1:0] ack_q;

  logic [NUM_EXT-1:0] rr_oh;
  logic               rr_valid;
  logic [NUM_EXT-1:0] arb_oh;
  int                 arb_i;
  int                 ack_i;
  int                 keep_w;
  logic [ADDR_W-1:0]  addr_mask;
  logic [ADDR_W-1:0]  ext_off;

  logic arb_point;
  logic ack_load;
  logic ext_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 2'd0;
      bc_q  <= BC_VIDEO;
    end else begin
      phase <= phase + 2'd1;
      bc_q  <= bc_d;
    end
  end

  always_comb begin
    bc_d      = bc_q;
    video_sel = 1'b0;
    cpu_sel   = 1'b0;
    ext_sel   = 1'b0;
    if (phase == PH_LAST)
      bc_d = bus_cycle_e'(bc_q + 2'd1);
    case (bc_q)
      BC_VIDEO:           video_sel = 1'b1;
      BC_CPU_A, BC_CPU_B: cpu_sel   = 1'b1;
      BC_EXT:             ext_sel   = 1'b1;
      default:            cpu_sel   = 1'b1;
    endcase
  end

  assign bus_cycle = bc_q;
  assign clk8_en_p = (phase == PH_LAST);
  assign clk8_en_n = (phase == PH_ARB);
  assign mem_latch = (phase == PH_LAST);

  assign arb_point = (bc_q == BC_CPU_A) && (phase == PH_ARB);
  assign ack_load  = (bc_q == BC_CPU_A) && (phase == PH_LAST);
  assign ext_end   = (bc_q == BC_EXT)   && (phase == PH_LAST);

  rr_arbiter #(.NUM_EXT(NUM_EXT)) u_rr_arbiter (
    .req      (bus.ext_req),
    .last     (last_grant),
    .grant_oh (rr_oh),
    .valid    (rr_valid)
  );

  // Fixed rotation ignores requests entirely: the slot is always taken.
  always_comb begin
    arb_oh = rr_oh;
    if (ROUND_ROBIN == 0)
      arb_oh = NUM_EXT'(1) << slot_count;
    arb_i = 0;
    for (int i = 0; i < NUM_EXT; i++)
      if (arb_oh[i]) arb_i = i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_count <= '0;
      last_grant <= IDX_W'(NUM_EXT - 1);
      grant_oh   <= '0;
      ack_q      <= '0;
    end else begin
      if (arb_point) begin
        grant_oh <= arb_oh;
        if (rr_valid || ROUND_ROBIN == 0)
          last_grant <= IDX_W'(arb_i);
      end
      if (ack_load)
        ack_q <= grant_oh;
      else if (ext_end)
        ack_q <= '0;
      if (ext_end)
        slot_count <= (slot_count == IDX_W'(NUM_EXT - 1)) ? '0 : slot_count + IDX_W'(1);
    end
  end

  assign bus.ext_ack = ack_q;

  always_comb begin
    ack_i = 0;
    for (int i = 0; i < NUM_EXT; i++)
      if (ack_q[i]) ack_i = i;
    keep_w = keep_bits(ram_size_cfg, ADDR_W);
    for (int b = 0; b < ADDR_W; b++)
      addr_mask[b] = (b < keep_w);
    ext_off = ADDR_W'(ack_i) << BASE_SHIFT;
  end

  // Ext offsets are absolute within the channel window and bypass RAM-size masking.
  always_comb begin
    if (|ack_q)
      bus.mem_addr = bus.ext_addr[ack_i*ADDR_W +: ADDR_W] + ext_off;
    else if (bc_q == BC_VIDEO)
      bus.mem_addr = bus.video_addr & addr_mask;
    else
      bus.mem_addr = bus.cpu_addr & addr_mask;
  end

endmodule

// File: tb/tb_mem_slot_sequencer.sv
// tb/tb_mem_slot_sequencer.sv - directed bench with a slot-timing reference model for RR and fixed modes
module tb_mem_slot_sequencer;

  localparam int NUM_EXT = 4;
  localparam int ADDR_W  = 22;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] cfg;
  logic [NUM_EXT-1:0] req;
  logic [NUM_EXT*ADDR_W-1:0] eaddr;
  logic [ADDR_W-1:0] cpu, vid;

  logic rr_p, rr_n, rr_l, rr_v, rr_c, rr_e;
  logic fx_p, fx_n, fx_l, fx_v, fx_c, fx_e;
  logic [1:0] rr_bc, fx_bc;

  mem_slot_sequencer_if #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W)) bus_rr ();
  mem_slot_sequencer_if #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W)) bus_fx ();

  assign bus_rr.ext_req    = req;
  assign bus_rr.ext_addr   = eaddr;
  assign bus_rr.cpu_addr   = cpu;
  assign bus_rr.video_addr = vid;
  assign bus_fx.ext_req    = '0;
  assign bus_fx.ext_addr   = eaddr;
  assign bus_fx.cpu_addr   = cpu;
  assign bus_fx.video_addr = vid;

  mem_slot_sequencer #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W), .ROUND_ROBIN(1), .BASE_SHIFT(20)) dut_rr (
    .clk(clk), .reset(reset), .clk8_en_p(rr_p), .clk8_en_n(rr_n), .mem_latch(rr_l),
    .bus_cycle(rr_bc), .video_sel(rr_v), .cpu_sel(rr_c), .ext_sel(rr_e),
    .ram_size_cfg(cfg), .bus(bus_rr)
  );

  mem_slot_sequencer #(.NUM_EXT(NUM_EXT), .ADDR_W(ADDR_W), .ROUND_ROBIN(0), .BASE_SHIFT(20)) dut_fx (
    .clk(clk), .reset(reset), .clk8_en_p(fx_p), .clk8_en_n(fx_n), .mem_latch(fx_l),
    .bus_cycle(fx_bc), .video_sel(fx_v), .cpu_sel(fx_c), .ext_sel(fx_e),
    .ram_size_cfg(cfg), .bus(bus_fx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tcnt = 0;

  // clocks elapsed since reset release
  always @(posedge clk) begin
    if (reset) tcnt <= 0;
    else       tcnt <= tcnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] masked(input logic [ADDR_W-1:0] a, input logic [1:0] c);
    int w;
    case (c)
      2'd0:    w = 17;
      2'd1:    w = 19;
      2'd2:    w = 20;
      default: w = 22;
    endcase
    return a & ADDR_W'((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input int bc, input int g);
    if (bc == 2 && g >= 0) return ADDR_W'(eaddr[g*ADDR_W +: ADDR_W] + (g << 20));
    if (bc == 0)           return masked(vid, cfg);
    return masked(cpu, cfg);
  endfunction

  task automatic check_dut(input string tag, input int t, input int g,
                           input logic [1:0] a_bc, input logic a_p, input logic a_n, input logic a_l,
                           input logic a_v, input logic a_c, input logic a_e,
                           input logic [NUM_EXT-1:0] a_ack, input logic [ADDR_W-1:0] a_addr);
    int ph, bc;
    ph = t % 4;
    bc = (t / 4) % 4;
    chk({tag, "_bus_cycle"}, a_bc, bc);
    chk({tag, "_clk8_en_p"}, a_p, ph == 3);
    chk({tag, "_clk8_en_n"}, a_n, ph == 1);
    chk({tag, "_mem_latch"}, a_l, ph == 3);
    chk({tag, "_video_sel"}, a_v, bc == 0);
    chk({tag, "_cpu_sel"},   a_c, bc == 1 || bc == 3);
    chk({tag, "_ext_sel"},   a_e, bc == 2);
    chk({tag, "_ext_ack"},   a_ack, (bc == 2 && g >= 0) ? (64'd1 << g) : 64'd0);
    chk({tag, "_mem_addr"},  a_addr, exp_addr(bc, (bc == 2) ? g : -1));
  endtask

  task automatic check_reset(input string tag, input logic [1:0] a_bc, input logic a_p, input logic a_n,
                             input logic a_l, input logic a_v, input logic [NUM_EXT-1:0] a_ack);
    chk({tag, "_rst_bus_cycle"}, a_bc, 0);
    chk({tag, "_rst_en_p"},      a_p, 0);
    chk({tag, "_rst_en_n"},      a_n, 0);
    chk({tag, "_rst_latch"},     a_l, 0);
    chk({tag, "_rst_video_sel"}, a_v, 1);
    chk({tag, "_rst_ack"},       a_ack, 0);
  endtask

  int rr_last = NUM_EXT - 1;
  int rr_g = -1;
  int m_t;
  int m_c;

  // Reference: 16-clock group; RR decision taken from ext_req seen at clock 5 of the group.
  always @(negedge clk) begin
    if (reset) begin
      rr_last = NUM_EXT - 1;
      rr_g    = -1;
      check_reset("rr", rr_bc, rr_p, rr_n, rr_l, rr_v, bus_rr.ext_ack);
      check_reset("fx", fx_bc, fx_p, fx_n, fx_l, fx_v, bus_fx.ext_ack);
    end else begin
      m_t = tcnt;
      if (m_t % 16 == 5) begin
        rr_g = -1;
        for (int k = 1; k <= NUM_EXT; k++) begin
          m_c = (rr_last + k) % NUM_EXT;
          if (rr_g < 0 && req[m_c]) rr_g = m_c;
        end
        if (rr_g >= 0) rr_last = rr_g;
      end
      check_dut("rr", m_t, rr_g, rr_bc, rr_p, rr_n, rr_l, rr_v, rr_c, rr_e, bus_rr.ext_ack, bus_rr.mem_addr);
      check_dut("fx", m_t, (m_t / 16) % NUM_EXT, fx_bc, fx_p, fx_n, fx_l, fx_v, fx_c, fx_e,
                bus_fx.ext_ack, bus_fx.mem_addr);
    end
  end

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (!reset && tcnt % 16 == ph) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: group clock %0d not reached, got timeout expected arrival", ph);
    end
  endtask

  logic [NUM_EXT-1:0] order_tab [5];
  logic [ADDR_W-1:0]  fx_addr_tab [5];

  initial begin
    order_tab   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fx_addr_tab = '{22'h000010, 22'h10ABCD, 22'h200123, 22'h2FFFFF, 22'h000010};
    cfg   = 2'd3;
    req   = '0;
    cpu   = 22'h3FFFFE;
    vid   = 22'h012345;
    eaddr = '0;
    eaddr[0*ADDR_W +: ADDR_W] = 22'h000010;
    eaddr[1*ADDR_W +: ADDR_W] = 22'h00ABCD;
    eaddr[2*ADDR_W +: ADDR_W] = 22'h000123;
    eaddr[3*ADDR_W +: ADDR_W] = 22'h3FFFFF;

    #1 reset = 1'b1;
    #1;
    chk("init_video_sel", rr_v, 1'b1);
    chk("init_bus_cycle", rr_bc, 2'd0);
    chk("init_rr_ack", bus_rr.ext_ack, 4'b0000);
    chk("init_fx_ack", bus_fx.ext_ack, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    req = 4'b1111;

    for (int k = 0; k < 5; k++) begin
      wait_phase(9);
      chk("rr_order", bus_rr.ext_ack, order_tab[k]);
      chk("fx_order", bus_fx.ext_ack, order_tab[k]);
      chk("fx_ext_addr", bus_fx.mem_addr, fx_addr_tab[k]);
    end

    @(posedge clk); #2 req = 4'b0011;
    wait_phase(9);
    chk("rr_ack_ch1", bus_rr.ext_ack, 4'b0010);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("rr_async_clear", bus_rr.ext_ack, 4'b0000);
    chk("fx_async_clear", bus_fx.ext_ack, 4'b0000);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    wait_phase(9);
    chk("rr_first_after_reset", bus_rr.ext_ack, 4'b0001);
    chk("fx_first_after_reset", bus_fx.ext_ack, 4'b0001);

    @(posedge clk); #2 req = 4'b0100;
    wait_phase(9);
    repeat (2) begin
      wait_phase(9);
      chk("rr_single_ack", bus_rr.ext_ack, 4'b0100);
      chk("rr_single_addr", bus_rr.mem_addr, 22'h200123);
    end

    @(posedge clk); #2 req = 4'b0010;
    wait_phase(9);
    wait_phase(6);
    @(posedge clk); #2 req = 4'b0000;
    wait_phase(9);
    chk("rr_grant_kept", bus_rr.ext_ack, 4'b0010);
    wait_phase(9);
    chk("rr_no_grant_ack", bus_rr.ext_ack, 4'b0000);
    chk("rr_no_grant_addr", bus_rr.mem_addr, 22'h3FFFFE);
    @(posedge clk); #2 req = 4'b1001;
    wait_phase(9);
    chk("rr_last_preserved", bus_rr.ext_ack, 4'b1000);

    @(posedge clk); #2 cfg = 2'd0;
    wait_phase(5);
    chk("cpu_a_128k", bus_rr.mem_addr, 22'h01FFFE);
    wait_phase(13);
    chk("cpu_b_128k", bus_rr.mem_addr, 22'h01FFFE);
    @(posedge clk); #2 cfg = 2'd3;
    wait_phase(5);
    chk("cpu_a_4m", bus_rr.mem_addr, 22'h3FFFFE);
    @(posedge clk); #2 cfg = 2'd1; vid = 22'h3ABCDE;
    wait_phase(1);
    chk("video_512k", bus_rr.mem_addr, 22'h02BCDE);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_slot_sequencer.md
MEM_SLOT_SEQUENCER -- requirements
Module: mem_slot_sequencer

Interface
REQ-001 Parameter NUM_EXT, default 4: number of extra-slot channels (2..8).
REQ-002 Parameter ADDR_W, default 22: memory word-address width.
REQ-003 Parameter ROUND_ROBIN, default 1: 1 = request-driven round-robin; 0 = fixed rotation with one slot per channel.
REQ-004 Parameter BASE_SHIFT, default 20: channel i base offset = i << BASE_SHIFT (channel 0 base 0).
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clk8_en_p / clk8_en_n  out  1 each  CPU clock enables: phase 3 and phase 1.
REQ-008 mem_latch  out  1  high in phase 3.
REQ-009 bus_cycle  out  2  current bus cycle number.
REQ-010 video_sel / cpu_sel / ext_sel  out  1 each  owner of the current bus cycle.
REQ-011 cpu_addr / video_addr  in  ADDR_W each  CPU and video word addresses.
REQ-012 ram_size_cfg  in  2  0=128K, 1=512K, 2=1M, 3=4M.
REQ-013 ext_req  in  NUM_EXT  per-channel access request, level-sensitive.
REQ-014 ext_addr  in  NUM_EXT*ADDR_W  per-channel offsets; channel i uses bits [i*ADDR_W +: ADDR_W].
REQ-015 ext_ack  out  NUM_EXT  one-hot; marks the granted channel's bus cycle.
REQ-016 mem_addr  out  ADDR_W  muxed memory address.

Function
REQ-017 The 2-bit phase counter SHALL increment every clk; bus_cycle SHALL increment (mod 4) when phase==3.
REQ-018 video_sel SHALL be high when bus_cycle==0; cpu_sel SHALL be high when bus_cycle is 1 or 3; ext_sel SHALL be high when bus_cycle==2.
REQ-019 Arbitration SHALL occur once per group, on the clk8_en_n (phase 1) of bus_cycle 1; the result SHALL be registered and held through bus_cycle 2.
REQ-020 ROUND_ROBIN=1: grant SHALL go to the first channel with ext_req high, searching from last_grant+1 upward and wrapping at NUM_EXT-1→0; if no request is high, no channel SHALL be granted and last_grant SHALL be unchanged.
REQ-021 ROUND_ROBIN=0: grant SHALL go to slot_count regardless of ext_req; slot_count SHALL increment mod NUM_EXT after each ext cycle.
REQ-022 ext_ack[g] SHALL be high during all 4 clocks of bus_cycle 2 for granted channel g, and all other ack bits SHALL be low.
REQ-023 A request deasserted after arbitration SHALL NOT cancel the grant.
REQ-024 A request asserted after the arbitration point SHALL be considered at the next group; worst-case wait is NUM_EXT groups (16*NUM_EXT clk).
REQ-025 mem_addr selection: an acked ext channel gives ext_addr[g] + (g << BASE_SHIFT), truncated to ADDR_W; video_sel gives video_addr masked; otherwise cpu_addr masked.
REQ-026 Masking SHALL force bits [ADDR_W-1:17] to 0 for size 0, bits [ADDR_W-1:19] to 0 for size 1, bits [ADDR_W-1:20] to 0 for size 2, and none for size 3; ext addresses SHALL NOT be masked.
REQ-027 mem_addr SHALL be combinational from registered state and the inputs; ext_ack SHALL be registered.
REQ-028 An ext cycle with no grant SHALL drive cpu_addr masked, with all ack bits low.

Reset
REQ-029 During reset: phase=0, bus_cycle=0, slot_count=0, last_grant=NUM_EXT-1, grant invalid, ext_ack=0; clk8_en_p=0, clk8_en_n=0, mem_latch=0, video_sel=1.
REQ-030 Reset asserted mid ext cycle SHALL clear ext_ack immediately (asynchronously); the first arbitration after release SHALL be at phase 1 of bus_cycle 1.

Structure
REQ-031 A shared package SHALL hold the bus-cycle encodings (VIDEO=0, CPU_A=1, EXT=2, CPU_B=3), the ram_size_cfg encodings, and the mask-width constants.
REQ-032 The round-robin priority search SHALL live in one sub-module, rr_arbiter (NUM_EXT parameter; inputs req and last; outputs grant_oh and valid).

Verification
REQ-033 After reset release, clk8_en_p SHALL pulse every 4 clk, and bus_cycle SHALL run 0,1,2,3 with 4 clk per step.
REQ-034 RR with ext_req=4'b1111 held: ack order SHALL be ch0,1,2,3,0 over consecutive groups, with no ack in bus_cycles 0, 1 or 3.
REQ-035 RR with ext_req=4'b0100 only, ext_addr[2]=22'h00123: ack[2] SHALL be high every group, and mem_addr SHALL be 22'h200123 during bus_cycle 2.
REQ-036 ROUND_ROBIN=0 with ext_req=0: acks SHALL still rotate 0..3, one per group.
REQ-037 ram_size_cfg=0, cpu_addr=22'h3FFFFE: mem_addr SHALL be 22'h01FFFE in cpu cycles; with ram_size_cfg=3 it SHALL be unchanged.
REQ-038 Reset pulse during ack[1]: ack SHALL drop in the same cycle; after release the first ack SHALL be ch0 when ext_req=4'b0011.
